// File: rtl/mem_store_queue_pkg.sv
// ---------------------------------------------------------------------------
// mem_store_queue_pkg : shared types for the store queue | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_store_queue_pkg;

  localparam int SAT_CNT_W = 8;

  typedef enum logic [1:0] {
    PUSH_NONE   = 2'd0,
    PUSH_ACCEPT = 2'd1,
    PUSH_MERGE  = 2'd2,
    PUSH_DROP   = 2'd3
  } push_kind_e;

  function automatic logic [SAT_CNT_W-1:0] sat_inc(input logic [SAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_store_queue_ng_cam.sv
// ---------------------------------------------------------------------------
// store_queue_cam : youngest-match forwarding lookup over pending stores | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_queue_cam
  import mem_store_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_mem [DEPTH],
  input  logic [DATA_W-1:0] data_mem [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  tail,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  logic [PTR_W-1:0] idx;

  // Walk from the youngest slot (tail-1) toward older ones; first match wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!lk_hit && valid[idx] && (addr_mem[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_mem[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_store_queue_ng.sv
// ---------------------------------------------------------------------------
// mem_store_queue_ng : CPU-to-memory store queue with merge and forwarding | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_store_queue_ng
  import mem_store_queue_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 16,
  parameter int EDGE_MODE = 1,
  parameter int MERGE_EN  = 0,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 can_write,
  output logic [ADDR_W-1:0]    addr_out,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  input  logic [ADDR_W-1:0]    lk_addr,
  output logic                 lk_hit,
  output logic [DATA_W-1:0]    lk_data,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic [SAT_CNT_W-1:0] drop_cnt,
  output logic [SAT_CNT_W-1:0] merge_cnt
);

  logic [ADDR_W-1:0]    addr_q [DEPTH];
  logic [ADDR_W-1:0]    addr_d [DEPTH];
  logic [DATA_W-1:0]    data_q [DEPTH];
  logic [DATA_W-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_en_dly_q, wr_en_dly_d;
  logic                 overflow_q, overflow_d;
  logic [SAT_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [SAT_CNT_W-1:0] merge_cnt_q, merge_cnt_d;

  logic             push_qual, pop, is_merge, accept, drop;
  logic [PTR_W-1:0] tail_m1;
  push_kind_e       push_kind;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));

  assign wr_en_dly_d = wr_en;
  assign push_qual   = (EDGE_MODE != 0) ? (wr_en & ~wr_en_dly_q) : wr_en;
  assign pop         = can_write & ~empty;
  assign tail_m1     = tail_q - PTR_W'(1);

  // A lone entry that is draining this cycle cannot be merged into.
  assign is_merge = (MERGE_EN != 0) && push_qual && !empty &&
                    (addr_in == addr_q[tail_m1]) &&
                    !((count_q == CNT_W'(1)) && pop);
  assign accept   = push_qual & ~is_merge & (~full | pop);
  assign drop     = push_qual & ~is_merge & full & ~pop;

  always_comb begin
    push_kind = PUSH_NONE;
    if (is_merge)    push_kind = PUSH_MERGE;
    else if (accept) push_kind = PUSH_ACCEPT;
    else if (drop)   push_kind = PUSH_DROP;
  end

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    merge_cnt_d = merge_cnt_q;

    // Pop is applied before accept so a full-queue push into the freed slot keeps its valid bit.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (accept) begin
      addr_d[tail_q]  = addr_in;
      data_d[tail_q]  = data_in;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (is_merge) begin
      data_d[tail_m1] = data_in;
      merge_cnt_d     = sat_inc(merge_cnt_q);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wr_en_dly_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      merge_cnt_q <= '0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      wr_en_dly_q <= wr_en_dly_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  store_queue_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cam (
    .addr_mem (addr_q),
    .data_mem (data_q),
    .valid    (valid_q),
    .tail     (tail_q),
    .lk_addr  (lk_addr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data)
  );

  assign addr_out   = addr_q[head_q];
  assign data_out   = data_q[head_q];
  assign data_valid = pop;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign merge_cnt  = merge_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_store_queue_ng.sv
// ---------------------------------------------------------------------------
// tb_mem_store_queue_ng : directed self-checking bench over four configurations | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_store_queue_ng;
  import mem_store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wr_en, can_write, ovf_clr;
  logic [15:0] addr_in, lk_addr;
  logic [7:0]  data_in;

  // a: default, l: level push, f: DEPTH=4, m: merge enabled
  logic [15:0] ao_a, ao_l, ao_f, ao_m;
  logic [7:0]  do_a, do_l, do_f, do_m;
  logic        dv_a, dv_l, dv_f, dv_m;
  logic        hit_a, hit_l, hit_f, hit_m;
  logic [7:0]  lkd_a, lkd_l, lkd_f, lkd_m;
  logic [4:0]  cnt_a, cnt_l, cnt_m;
  logic [2:0]  cnt_f;
  logic        full_a, full_l, full_f, full_m;
  logic        emp_a, emp_l, emp_f, emp_m;
  logic        af_a, af_l, af_f, af_m;
  logic        ovf_a, ovf_l, ovf_f, ovf_m;
  logic [7:0]  dc_a, dc_l, dc_f, dc_m;
  logic [7:0]  mc_a, mc_l, mc_f, mc_m;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_store_queue_ng u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr_in(addr_in), .data_in(data_in),
    .can_write(can_write), .addr_out(ao_a), .data_out(do_a), .data_valid(dv_a),
    .lk_addr(lk_addr), .lk_hit(hit_a), .lk_data(lkd_a), .count(cnt_a), .full(full_a),
    .empty(emp_a), .almost_full(af_a), .overflow(ovf_a), .ovf_clr(ovf_clr),
    .drop_cnt(dc_a), .merge_cnt(mc_a));

  mem_store_queue_ng #(.EDGE_MODE(0)) u_l (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr_in(addr_in), .data_in(data_in),
    .can_write(can_write), .addr_out(ao_l), .data_out(do_l), .data_valid(dv_l),
    .lk_addr(lk_addr), .lk_hit(hit_l), .lk_data(lkd_l), .count(cnt_l), .full(full_l),
    .empty(emp_l), .almost_full(af_l), .overflow(ovf_l), .ovf_clr(ovf_clr),
    .drop_cnt(dc_l), .merge_cnt(mc_l));

  mem_store_queue_ng #(.DEPTH(4)) u_f (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr_in(addr_in), .data_in(data_in),
    .can_write(can_write), .addr_out(ao_f), .data_out(do_f), .data_valid(dv_f),
    .lk_addr(lk_addr), .lk_hit(hit_f), .lk_data(lkd_f), .count(cnt_f), .full(full_f),
    .empty(emp_f), .almost_full(af_f), .overflow(ovf_f), .ovf_clr(ovf_clr),
    .drop_cnt(dc_f), .merge_cnt(mc_f));

  mem_store_queue_ng #(.MERGE_EN(1)) u_m (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr_in(addr_in), .data_in(data_in),
    .can_write(can_write), .addr_out(ao_m), .data_out(do_m), .data_valid(dv_m),
    .lk_addr(lk_addr), .lk_hit(hit_m), .lk_data(lkd_m), .count(cnt_m), .full(full_m),
    .empty(emp_m), .almost_full(af_m), .overflow(ovf_m), .ovf_clr(ovf_clr),
    .drop_cnt(dc_m), .merge_cnt(mc_m));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; can_write = 1'b0; ovf_clr = 1'b0;
    addr_in = '0; data_in = '0; lk_addr = 16'hFFFF;
    tick();
    rst = 1'b0;
  endtask

  // One rising edge of wr_en followed by a low cycle to re-arm edge detection.
  task automatic push_edge(input logic [15:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr_in = a; data_in = d;
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    can_write = 1'b1; lk_addr = 16'h0000;
    #1;
    n_total++; if (emp_a !== 1'b1) $display("FAIL reset_empty: got %0b want 1", emp_a); else n_pass++;
    n_total++; if (full_a !== 1'b0) $display("FAIL reset_full: got %0b want 0", full_a); else n_pass++;
    n_total++; if (af_a !== 1'b0) $display("FAIL reset_af: got %0b want 0", af_a); else n_pass++;
    n_total++; if (dv_a !== 1'b0) $display("FAIL reset_dv: got %0b want 0", dv_a); else n_pass++;
    n_total++; if (hit_a !== 1'b0) $display("FAIL reset_hit: got %0b want 0", hit_a); else n_pass++;
    n_total++; if (cnt_a !== 5'd0) $display("FAIL reset_count: got %0d want 0", cnt_a); else n_pass++;
    n_total++; if (ao_a !== 16'h0 || do_a !== 8'h0 || lkd_a !== 8'h0)
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", ao_a, do_a, lkd_a); else n_pass++;
    n_total++; if (ovf_a !== 1'b0 || dc_a !== 8'd0 || mc_a !== 8'd0)
      $display("FAIL reset_stats: got %0b/%0d/%0d want 0/0/0", ovf_a, dc_a, mc_a); else n_pass++;
    can_write = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] ea [3];
    logic [7:0]  ed [3];
    ea[0] = 16'h2000; ea[1] = 16'h2001; ea[2] = 16'h2002;
    ed[0] = 8'hA1;    ed[1] = 8'hB2;    ed[2] = 8'hC3;
    do_reset();
    for (int i = 0; i < 3; i++) push_edge(ea[i], ed[i]);
    n_total++; if (cnt_a !== 5'd3) $display("FAIL basic_count: got %0d want 3", cnt_a); else n_pass++;
    n_total++; if (ao_a !== 16'h2000 || do_a !== 8'hA1 || dv_a !== 1'b0)
      $display("FAIL basic_head: got %h/%h dv=%0b want 2000/a1 dv=0", ao_a, do_a, dv_a); else n_pass++;
    can_write = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (dv_a !== 1'b1 || ao_a !== ea[i] || do_a !== ed[i])
        $display("FAIL basic_drain%0d: got %h/%h dv=%0b want %h/%h dv=1", i, ao_a, do_a, dv_a, ea[i], ed[i]);
      else n_pass++;
      tick();
    end
    n_total++; if (emp_a !== 1'b1 || dv_a !== 1'b0 || cnt_a !== 5'd0)
      $display("FAIL basic_empty: got empty=%0b dv=%0b cnt=%0d want 1/0/0", emp_a, dv_a, cnt_a); else n_pass++;
    can_write = 1'b0;
  endtask

  task automatic test_edge_level();
    do_reset();
    wr_en = 1'b1; addr_in = 16'h3000; data_in = 8'h55;
    repeat (5) tick();
    wr_en = 1'b0;
    tick();
    n_total++; if (cnt_a !== 5'd1) $display("FAIL edge_count: got %0d want 1", cnt_a); else n_pass++;
    n_total++; if (cnt_l !== 5'd5) $display("FAIL level_count: got %0d want 5", cnt_l); else n_pass++;
    lk_addr = 16'h3000;
    #1;
    n_total++; if (hit_l !== 1'b1 || lkd_l !== 8'h55)
      $display("FAIL level_lookup: got hit=%0b data=%h want 1/55", hit_l, lkd_l); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) push_edge(16'h4000 + 16'(i), 8'(8'h40 + i));
    n_total++; if (full_f !== 1'b1 || cnt_f !== 3'd4 || af_f !== 1'b1)
      $display("FAIL ovf_fill: got full=%0b cnt=%0d af=%0b want 1/4/1", full_f, cnt_f, af_f); else n_pass++;
    wr_en = 1'b1; addr_in = 16'h4004; data_in = 8'h44;
    #1;
    n_total++; if (u_f.push_kind !== PUSH_DROP)
      $display("FAIL ovf_kind: got %0d want %0d", u_f.push_kind, PUSH_DROP); else n_pass++;
    tick();
    wr_en = 1'b0;
    n_total++; if (ovf_f !== 1'b1 || dc_f !== 8'd1 || cnt_f !== 3'd4 || ao_f !== 16'h4000)
      $display("FAIL ovf_drop: got ovf=%0b dc=%0d cnt=%0d head=%h want 1/1/4/4000", ovf_f, dc_f, cnt_f, ao_f);
    else n_pass++;
    tick();
    wr_en = 1'b1; can_write = 1'b1; addr_in = 16'h4005; data_in = 8'h45;
    tick();
    n_total++; if (cnt_f !== 3'd4 || ao_f !== 16'h4001 || dc_f !== 8'd1)
      $display("FAIL ovf_full_pop: got cnt=%0d head=%h dc=%0d want 4/4001/1", cnt_f, ao_f, dc_f); else n_pass++;
    wr_en = 1'b0; can_write = 1'b0; lk_addr = 16'h4005;
    #1;
    n_total++; if (hit_f !== 1'b1 || lkd_f !== 8'h45)
      $display("FAIL ovf_accepted: got hit=%0b data=%h want 1/45", hit_f, lkd_f); else n_pass++;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_total++; if (ovf_f !== 1'b0 || dc_f !== 8'd0)
      $display("FAIL ovf_clr: got ovf=%0b dc=%0d want 0/0", ovf_f, dc_f); else n_pass++;
  endtask

  task automatic test_merge();
    do_reset();
    push_edge(16'h1820, 8'h11);
    wr_en = 1'b1; addr_in = 16'h1820; data_in = 8'h22;
    #1;
    n_total++; if (u_m.push_kind !== PUSH_MERGE)
      $display("FAIL merge_kind: got %0d want %0d", u_m.push_kind, PUSH_MERGE); else n_pass++;
    tick();
    wr_en = 1'b0;
    tick();
    n_total++; if (cnt_m !== 5'd1 || do_m !== 8'h22 || mc_m !== 8'd1)
      $display("FAIL merge_same: got cnt=%0d data=%h mc=%0d want 1/22/1", cnt_m, do_m, mc_m); else n_pass++;
    n_total++; if (cnt_a !== 5'd2)
      $display("FAIL merge_disabled: got cnt=%0d want 2", cnt_a); else n_pass++;
    push_edge(16'h1821, 8'h33);
    push_edge(16'h1820, 8'h44);
    n_total++; if (cnt_m !== 5'd3 || mc_m !== 8'd1)
      $display("FAIL merge_nonyoung: got cnt=%0d mc=%0d want 3/1", cnt_m, mc_m); else n_pass++;
    lk_addr = 16'h1820;
    #1;
    n_total++; if (hit_m !== 1'b1 || lkd_m !== 8'h44)
      $display("FAIL merge_lookup: got hit=%0b data=%h want 1/44", hit_m, lkd_m); else n_pass++;
  endtask

  task automatic test_lookup();
    do_reset();
    lk_addr = 16'h0100;
    push_edge(16'h0100, 8'h5A);
    n_total++; if (hit_a !== 1'b1 || lkd_a !== 8'h5A)
      $display("FAIL lk_single: got hit=%0b data=%h want 1/5a", hit_a, lkd_a); else n_pass++;
    wr_en = 1'b1; addr_in = 16'h0100; data_in = 8'h6B;
    #1;
    n_total++; if (lkd_a !== 8'h5A)
      $display("FAIL lk_same_cycle: got data=%h want 5a", lkd_a); else n_pass++;
    tick();
    wr_en = 1'b0;
    tick();
    n_total++; if (hit_a !== 1'b1 || lkd_a !== 8'h6B)
      $display("FAIL lk_youngest: got hit=%0b data=%h want 1/6b", hit_a, lkd_a); else n_pass++;
    lk_addr = 16'h0101;
    #1;
    n_total++; if (hit_a !== 1'b0 || lkd_a !== 8'h00)
      $display("FAIL lk_miss: got hit=%0b data=%h want 0/00", hit_a, lkd_a); else n_pass++;
    lk_addr = 16'h0100; can_write = 1'b1;
    #1;
    n_total++; if (hit_a !== 1'b1 || lkd_a !== 8'h6B || dv_a !== 1'b1)
      $display("FAIL lk_draining: got hit=%0b data=%h dv=%0b want 1/6b/1", hit_a, lkd_a, dv_a); else n_pass++;
    tick();
    n_total++; if (hit_a !== 1'b1 || lkd_a !== 8'h6B || cnt_a !== 5'd1)
      $display("FAIL lk_one_left: got hit=%0b data=%h cnt=%0d want 1/6b/1", hit_a, lkd_a, cnt_a); else n_pass++;
    tick();
    n_total++; if (hit_a !== 1'b0 || emp_a !== 1'b1)
      $display("FAIL lk_drained: got hit=%0b empty=%0b want 0/1", hit_a, emp_a); else n_pass++;
    can_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea;
    logic [7:0]  ed;
    do_reset();
    push_edge(16'h5000, 8'h00);
    push_edge(16'h5001, 8'h01);
    for (int k = 0; k < 10; k++) begin
      ea = 16'h5000 + 16'(k);
      ed = 8'(k);
      wr_en = 1'b1; can_write = 1'b1; addr_in = 16'h5000 + 16'(k + 2); data_in = 8'(k + 2);
      #1;
      n_total++; if (dv_f !== 1'b1 || ao_f !== ea || do_f !== ed)
        $display("FAIL wrap_head%0d: got %h/%h dv=%0b want %h/%h dv=1", k, ao_f, do_f, dv_f, ea, ed);
      else n_pass++;
      tick();
      wr_en = 1'b0; can_write = 1'b0;
      tick();
      n_total++; if (cnt_f !== 3'd2 || full_f !== 1'b0 || emp_f !== 1'b0)
        $display("FAIL wrap_count%0d: got cnt=%0d full=%0b empty=%0b want 2/0/0", k, cnt_f, full_f, emp_f);
      else n_pass++;
    end
    rst = 1'b1; can_write = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (emp_f !== 1'b1 || dv_f !== 1'b0 || cnt_f !== 3'd0)
      $display("FAIL wrap_reset: got empty=%0b dv=%0b cnt=%0d want 1/0/0", emp_f, dv_f, cnt_f); else n_pass++;
    can_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_edge_level();
    test_overflow();
    test_merge();
    test_lookup();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_store_queue_ng.md
Name: mem_store_queue_ng

Overview:
- Next-generation CPU-to-memory store queue. Buffers {address, data} write requests from the 6502 core bus and drains them one per cycle when the downstream memory grants a write slot.
- Additions over the previous generation: parametrised widths and depth, selectable level/edge push qualification, optional tail merge of same-address writes, overflow accounting, and a read-forwarding lookup port so core reads observe pending stores.
- Sits between the address decoder's write path and the BRAM/vector-RAM write ports.

Parameters:
- DATA_W, 8, data width of each entry.
- ADDR_W, 16, address width of each entry.
- DEPTH, 16, number of entries; power of two, 2..256.
- EDGE_MODE, 1, 1: push on rising edge of wr_en; 0: push every cycle wr_en is high.
- MERGE_EN, 0, 1: a push to the same address as the youngest pending entry overwrites that entry in place.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- addr_in  in  ADDR_W  push address.
- data_in  in  DATA_W  push data.
- can_write  in  1  downstream grants one drain this cycle.
- addr_out  out  ADDR_W  head entry address.
- data_out  out  DATA_W  head entry data.
- data_valid  out  1  head is being drained this cycle.
- lk_addr  in  ADDR_W  forwarding lookup address.
- lk_hit  out  1  a pending entry matches lk_addr.
- lk_data  out  DATA_W  data of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  occupancy.
- full, empty, almost_full  out  1  status flags.
- overflow  out  1  sticky: a push was dropped.
- ovf_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  8  saturating count of dropped pushes.
- merge_cnt  out  8  saturating count of merged pushes.

Behaviour:
- Reset (clk edge with rst=1): pointers, count, valid bits, overflow, drop_cnt and merge_cnt all 0. After reset: empty=1, full=0, almost_full=0, data_valid=0, lk_hit=0. addr_out, data_out and lk_data read 0 because storage is cleared. Reset mid-operation discards all pending entries.
- push_q = EDGE_MODE ? (wr_en & ~wr_en_d) : wr_en. wr_en_d is a registered copy of wr_en, reset to 0.
- pop = can_write & ~empty. data_valid = pop, combinational. addr_out and data_out are the head entry, combinational (zero-latency drain).
- merge = MERGE_EN & push_q & ~empty & (addr_in == addr of tail-1) & ~(count==1 & pop).
  - Overwrites the youngest entry's data; count is unchanged; merge_cnt++ (saturates at 255).
  - merge takes priority over a normal push. A simultaneous pop of a different entry proceeds normally.
- accept = push_q & ~merge & (~full | pop). Full plus a simultaneous pop accepts the push: the slot frees in the same cycle.
- drop = push_q & ~merge & full & ~pop. On drop: overflow<=1 and drop_cnt++ (saturates at 255). Queue contents unchanged.
- Count update: +1 on accept only, -1 on pop only, unchanged when both occur. Pointers wrap modulo DEPTH.
- full = (count==DEPTH). empty = (count==0). almost_full = (count>=AF_THRESH). All three derive from count registered this cycle.
- ovf_clr has priority over a same-cycle drop: overflow<=0 and drop_cnt<=0. merge_cnt is not cleared by ovf_clr.
- Lookup is combinational over all valid entries, including the head even while it drains.
  - lk_hit is 1 if any valid entry matches lk_addr.
  - lk_data comes from the matching entry nearest the tail (youngest); otherwise 0.
  - A push or merge in the current cycle is not visible until the next cycle.
- data_in and addr_in are sampled only on the accept or merge cycle.

Decomposition:
- Package mem_store_queue_pkg:
  - saturating 8-bit counter width constant SAT_CNT_W=8;
  - typedef enum for push outcome {PUSH_NONE, PUSH_ACCEPT, PUSH_MERGE, PUSH_DROP}, used by the control logic and exported to the bench via hierarchy.
- One sub-module: store_queue_cam.
  - Parametrised DEPTH/ADDR_W/DATA_W.
  - Inputs: entry arrays, valid bits, tail pointer, lk_addr.
  - Outputs: youngest-match hit and data, using a priority scan ordered from tail-1 backward.
- The existing register primitive holds wr_en_d.

Test Plan:
- Reset then 3 edge pushes (0x2000/0xA1, 0x2001/0xB2, 0x2002/0xC3), can_write=0 -> count=3, head 0x2000/0xA1. Raise can_write -> data_valid for 3 consecutive cycles in push order, then empty=1.
- EDGE_MODE=1, wr_en held high 5 cycles -> exactly 1 entry. EDGE_MODE=0, same stimulus -> 5 entries.
- DEPTH=4: fill to full, push again with can_write=0 -> drop, overflow=1, drop_cnt=1. Push with can_write=1 at full -> accepted, count stays 4. ovf_clr -> overflow=0, drop_cnt=0.
- MERGE_EN=1: push 0x1820/0x11 then 0x1820/0x22 -> count=1, head data 0x22, merge_cnt=1. Push 0x1821/0x33 then 0x1820/0x44 -> no merge, count=3.
- Lookup: pending 0x0100/0x5A and 0x0100/0x6B (MERGE_EN=0), lk_addr=0x0100 -> lk_hit=1, lk_data=0x6B. lk_addr=0x0101 -> lk_hit=0. After both drain -> lk_hit=0.
- Pointer wrap: DEPTH=4, 10 interleaved push/pop pairs with simultaneous push and pop -> count constant, FIFO order preserved, no spurious full/empty. Assert rst with 2 pending -> next cycle empty=1, data_valid=0.
